// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word-boundary alignment via bitslip on control-token runs,
// followed by 10b->8b decode into pixel data, data-enable and control bits.
module tmds_channel_decoder #(
    parameter int unsigned CTRL_RUN       = 16,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned SLIP_WAIT      = 4,
    parameter int unsigned LOCK_TIMEOUT   = 4096
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [9:0] sym_in,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic [7:0] data_out
);

    localparam int unsigned TMR_MAX0 = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
    localparam int unsigned TMR_MAX  = (TMR_MAX0 > SLIP_WAIT) ? TMR_MAX0 : SLIP_WAIT;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
    localparam int unsigned RUN_W    = $clog2(CTRL_RUN + 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [RUN_W-1:0] run_cnt;

    logic             is_ctrl_c;
    logic [1:0]       ctrl_c;
    logic [7:0]       q_c;
    logic [7:0]       dec_c;
    logic [RUN_W-1:0] run_nxt_c;
    logic             qual_c;
    logic             lock_nxt_c;

    // Token detection and data-symbol decode
    always_comb begin
        is_ctrl_c = 1'b1;
        ctrl_c    = 2'b00;
        case (sym_in)
            10'b1101010100: ctrl_c = 2'b00;
            10'b0010101011: ctrl_c = 2'b01;
            10'b0101010100: ctrl_c = 2'b10;
            10'b1010101011: ctrl_c = 2'b11;
            default:        is_ctrl_c = 1'b0;
        endcase
        q_c      = sym_in[9] ? ~sym_in[7:0] : sym_in[7:0];
        dec_c    = 8'h00;
        dec_c[0] = q_c[0];
        for (int i = 1; i < 8; i++) begin
            dec_c[i] = sym_in[8] ? (q_c[i] ^ q_c[i-1]) : ~(q_c[i] ^ q_c[i-1]);
        end
    end

    // Run tracking; lock_nxt_c says whether this sample is decoded as aligned
    always_comb begin
        run_nxt_c = '0;
        if (is_ctrl_c) begin
            run_nxt_c = (run_cnt == RUN_W'(CTRL_RUN)) ? run_cnt : run_cnt + RUN_W'(1);
        end
        qual_c     = is_ctrl_c && (run_cnt == RUN_W'(CTRL_RUN - 1));
        lock_nxt_c = 1'b0;
        case (state)
            ST_SEARCH: lock_nxt_c = qual_c;
            ST_LOCKED: lock_nxt_c = qual_c || (tmr != TMR_W'(LOCK_TIMEOUT - 1));
            default:   lock_nxt_c = 1'b0;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SEARCH;
            tmr      <= '0;
            run_cnt  <= '0;
            bitslip  <= 1'b0;
            aligned  <= 1'b0;
            de       <= 1'b0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            data_out <= 8'h00;
        end else begin
            bitslip <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    run_cnt <= run_nxt_c;
                    if (qual_c) begin
                        state <= ST_LOCKED;
                        tmr   <= '0;
                    end else if (tmr == TMR_W'(SEARCH_TIMEOUT - 1)) begin
                        state   <= ST_SLIP;
                        bitslip <= 1'b1;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_SLIP: begin
                    run_cnt <= '0;
                    tmr     <= '0;
                    state   <= ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    // Deserializer is settling; symbols are not trusted here
                    run_cnt <= '0;
                    if (tmr == TMR_W'(SLIP_WAIT - 1)) begin
                        state <= ST_SEARCH;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_LOCKED: begin
                    run_cnt <= run_nxt_c;
                    if (qual_c) begin
                        tmr <= '0;
                    end else if (tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        state   <= ST_SEARCH;
                        tmr     <= '0;
                        run_cnt <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: state <= ST_SEARCH;
            endcase

            aligned <= lock_nxt_c;
            if (lock_nxt_c) begin
                de <= ~is_ctrl_c;
                if (is_ctrl_c) begin
                    c1       <= ctrl_c[1];
                    c0       <= ctrl_c[0];
                    data_out <= 8'h00;
                end else begin
                    data_out <= dec_c;
                end
            end else begin
                de       <= 1'b0;
                data_out <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: bit-level deserializer model with bitslip plus a
// deadline-based reference model of alignment and decode, compared every cycle.
module tb_tmds_channel_decoder;

    localparam int CTRL_RUN       = 16;
    localparam int SEARCH_TIMEOUT = 2048;
    localparam int SLIP_WAIT      = 4;
    localparam int LOCK_TIMEOUT   = 4096;

    localparam int M_SEARCH = 0;
    localparam int M_SLIP   = 1;
    localparam int M_WAIT   = 2;
    localparam int M_LOCK   = 3;

    logic       pclk;
    logic       rst_n;
    logic [9:0] sym_in;
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] data_out;

    int n_checks;
    int n_errors;

    logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Deserializer model: lag = bits the word boundary sits away from true alignment
    logic [9:0] prev_sym;
    logic [9:0] cur_sym;
    int         lag;

    // Reference model state
    int         m_mode;
    int         m_run;
    int         m_dead;
    int         m_cyc;
    logic       m_bs;
    logic       m_al;
    logic       m_de;
    logic [1:0] m_c;
    logic [7:0] m_d;

    tmds_channel_decoder #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .SLIP_WAIT     (SLIP_WAIT),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT)
    ) dut (
        .pclk    (pclk),
        .rst_n   (rst_n),
        .sym_in  (sym_in),
        .bitslip (bitslip),
        .aligned (aligned),
        .de      (de),
        .c0      (c0),
        .c1      (c1),
        .data_out(data_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] x;
        q = s[9] ? ~s[7:0] : s[7:0];
        x = q ^ {q[6:0], 1'b0};
        if (!s[8]) x = x ^ 8'hFE;
        return x;
    endfunction

    function automatic int tok_index(input logic [9:0] s);
        for (int k = 0; k < 4; k++) if (s == tok_tab[k]) return k;
        return -1;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        s = 10'($urandom);
        while (tok_index(s) >= 0) s = 10'($urandom);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_SEARCH;
        m_run  = 0;
        m_cyc  = 0;
        m_dead = SEARCH_TIMEOUT;
        m_bs   = 1'b0;
        m_al   = 1'b0;
        m_de   = 1'b0;
        m_c    = 2'b00;
        m_d    = 8'h00;
    endtask

    // Deadline-based model: a timeout is the absolute edge number where it fires
    task automatic model_step(input logic [9:0] s);
        int  tv;
        bit  tok;
        bit  qual;
        m_cyc++;
        tv   = tok_index(s);
        tok  = (tv >= 0);
        qual = 1'b0;
        m_bs = 1'b0;
        case (m_mode)
            M_SEARCH: begin
                m_run = tok ? m_run + 1 : 0;
                qual  = tok && (m_run == CTRL_RUN);
                if (qual) begin
                    m_mode = M_LOCK;
                    m_dead = m_cyc + LOCK_TIMEOUT;
                end else if (m_cyc == m_dead) begin
                    m_mode = M_SLIP;
                    m_bs   = 1'b1;
                end
            end
            M_SLIP: begin
                m_run  = 0;
                m_mode = M_WAIT;
                m_dead = m_cyc + SLIP_WAIT;
            end
            M_WAIT: begin
                m_run = 0;
                if (m_cyc == m_dead) begin
                    m_mode = M_SEARCH;
                    m_dead = m_cyc + SEARCH_TIMEOUT;
                end
            end
            default: begin
                m_run = tok ? m_run + 1 : 0;
                qual  = tok && (m_run == CTRL_RUN);
                if (qual) begin
                    m_dead = m_cyc + LOCK_TIMEOUT;
                end else if (m_cyc == m_dead) begin
                    m_mode = M_SEARCH;
                    m_dead = m_cyc + SEARCH_TIMEOUT;
                    m_run  = 0;
                end
            end
        endcase
        m_al = (m_mode == M_LOCK);
        if (m_al && tok) begin
            m_de = 1'b0;
            m_d  = 8'h00;
            m_c  = 2'(tv);
        end else if (m_al) begin
            m_de = 1'b1;
            m_d  = ref_decode(s);
        end else begin
            m_de = 1'b0;
            m_d  = 8'h00;
        end
    endtask

    // One pixel clock: push a source symbol through the deserializer, clock, compare
    task automatic step(input logic [9:0] src);
        logic [19:0] pair;
        logic        slip_req;
        prev_sym = cur_sym;
        cur_sym  = src;
        pair     = {cur_sym, prev_sym} >> (10 - lag);
        sym_in   = pair[9:0];
        slip_req = bitslip;
        @(posedge pclk);
        if (slip_req) lag = (lag + 9) % 10;
        model_step(sym_in);
        #1;
        check("cycle", {19'h0, bitslip, aligned, de, c1, c0, data_out},
              {19'h0, m_bs, m_al, m_de, m_c, m_d});
    endtask

    function automatic logic [9:0] line_sym(input int n);
        if ((n % 50) < 20) return tok_tab[0];
        return rand_data();
    endfunction

    initial begin
        int nslips;
        int last_slip;
        int fall_at;
        int slip_at;
        n_checks = 0;
        n_errors = 0;
        prev_sym = 10'h0;
        cur_sym  = 10'h0;
        lag      = 0;
        rst_n    = 1'b0;
        sym_in   = 10'h0;
        model_reset();

        // Reset holds all outputs low regardless of input
        for (int i = 0; i < 8; i++) begin
            sym_in = 10'($urandom);
            @(negedge pclk);
            check("rst_out", {19'h0, bitslip, aligned, de, c1, c0, data_out}, 32'h0);
        end
        rst_n = 1'b1;
        model_reset();

        // Lock on 16 tokens, then decode
        for (int i = 0; i < CTRL_RUN; i++) begin
            step(tok_tab[0]);
            if (i == CTRL_RUN - 2) check("pre_lock_aligned", 32'(aligned), 32'd0);
        end
        check("lock_aligned", 32'(aligned), 32'd1);
        check("lock_tok_de", 32'(de), 32'd0);
        check("lock_bitslip", 32'(bitslip), 32'd0);
        step(10'h100);
        check("d100_de", 32'(de), 32'd1);
        check("d100_data", 32'(data_out), 32'h00);
        step(10'h2FF);
        check("d2ff_data", 32'(data_out), 32'hFE);
        check("d2ff_de", 32'(de), 32'd1);
        step(10'b1010101011);
        check("tok11_de", 32'(de), 32'd0);
        check("tok11_c", 32'({c1, c0}), 32'd3);
        step(rand_data());
        check("hold_c", 32'({c1, c0}), 32'd3);
        check("hold_de", 32'(de), 32'd1);

        // Random video-like lines while locked
        for (int ln = 0; ln < 12; ln++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            for (int i = 0; i < int'($urandom_range(10, 36)); i++) step(tok_tab[kind]);
            for (int i = 0; i < int'($urandom_range(1, 60)); i++) begin
                if ($urandom_range(0, 9) == 0) step(tok_tab[$urandom_range(0, 3)]);
                else step(rand_data());
            end
        end
        // Fresh qualifying run so the lock timer restarts on a known edge
        step(rand_data());
        for (int i = 0; i < CTRL_RUN; i++) step(tok_tab[1]);
        check("requal_aligned", 32'(aligned), 32'd1);

        // Lock loss on data-only stream, then a slip SEARCH_TIMEOUT later
        fall_at = -1;
        for (int n = 1; n <= LOCK_TIMEOUT + 20; n++) begin
            step(rand_data());
            if (!aligned) begin
                fall_at = n;
                break;
            end
        end
        check("loss_edge", 32'(fall_at), 32'(LOCK_TIMEOUT));
        check("loss_de", 32'(de), 32'd0);
        slip_at = -1;
        for (int n = 1; n <= SEARCH_TIMEOUT + 20; n++) begin
            step(rand_data());
            if (bitslip) begin
                slip_at = n;
                break;
            end
        end
        check("loss_slip_gap", 32'(slip_at), 32'(SEARCH_TIMEOUT));

        // Asynchronous reset while bitslip is high
        if (bitslip) begin
            rst_n = 1'b0;
            #1;
            check("arst_out", {19'h0, bitslip, aligned, de, c1, c0, data_out}, 32'h0);
        end else begin
            check("arst_slip_seen", 32'(bitslip), 32'd1);
            rst_n = 1'b0;
        end
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        model_reset();

        // Misaligned by 3 bits: expect exactly three evenly spaced slips, then lock
        lag       = 3;
        nslips    = 0;
        last_slip = -1;
        for (int n = 0; n < 4 * (SEARCH_TIMEOUT + SLIP_WAIT + 1) + 200; n++) begin
            step(line_sym(n));
            if (bitslip) begin
                if (nslips == 0) check("slip1_at", 32'(n), 32'(SEARCH_TIMEOUT - 1));
                else check("slip_gap", 32'(n - last_slip), 32'(SEARCH_TIMEOUT + SLIP_WAIT + 1));
                nslips++;
                last_slip = n;
            end
            if (aligned) break;
        end
        check("slip_count", 32'(nslips), 32'd3);
        check("relock", 32'(aligned), 32'd1);
        for (int n = 0; n < 200; n++) step(line_sym(n));
        check("stay_locked", 32'(aligned), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
